// File: rtl/riscv_pkg.sv
// Shared RV32 control constants: opcodes, ALU operation codes and sequencer state encoding.
package riscv_pkg;

   localparam int SEL_W = 4;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [SEL_W-1:0] ALU_ADD   = 4'b0000;
   localparam logic [SEL_W-1:0] ALU_SUB   = 4'b0001;
   localparam logic [SEL_W-1:0] ALU_ADDI  = 4'b0010;
   localparam logic [SEL_W-1:0] ALU_BEQ   = 4'b0110;
   localparam logic [SEL_W-1:0] ALU_BNE   = 4'b0111;
   localparam logic [SEL_W-1:0] ALU_BLT   = 4'b1001;
   localparam logic [SEL_W-1:0] ALU_BLTU  = 4'b1010;
   localparam logic [SEL_W-1:0] ALU_JALR  = 4'b1011;
   localparam logic [SEL_W-1:0] ALU_JAL   = 4'b1100;
   localparam logic [SEL_W-1:0] ALU_AUIPC = 4'b1101;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational instruction classifier: latched IR -> ALU op, instruction class flags, legality.
module rv_ctrl_decode
   import riscv_pkg::*;
(
   input  logic [31:0]      ir,
   output logic [SEL_W-1:0] alu_sel,
   output logic             is_load,
   output logic             is_store,
   output logic             is_branch,
   output logic             uses_imm,
   output logic             writes_rd,
   output logic             illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       rd_nonzero;
   logic       unused_ir_bits;

   assign opcode         = ir[6:0];
   assign funct3         = ir[14:12];
   assign funct7         = ir[31:25];
   assign rd_nonzero     = |ir[11:7];
   assign unused_ir_bits = ^ir[24:15];

   always_comb begin
      alu_sel   = ALU_ADD;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      uses_imm  = 1'b0;
      writes_rd = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OP: begin
            writes_rd = rd_nonzero;
            if (funct3 == 3'b000 && funct7 == 7'b0000000)      alu_sel = ALU_ADD;
            else if (funct3 == 3'b000 && funct7 == 7'b0100000) alu_sel = ALU_SUB;
            else                                               illegal = 1'b1;
         end
         OP_IMM: begin
            alu_sel   = ALU_ADDI;
            uses_imm  = 1'b1;
            writes_rd = rd_nonzero;
            illegal   = (funct3 != 3'b000);
         end
         LOAD: begin
            alu_sel   = ALU_ADDI;
            uses_imm  = 1'b1;
            is_load   = 1'b1;
            writes_rd = rd_nonzero;
            illegal   = (funct3 != 3'b010);
         end
         STORE: begin
            alu_sel  = ALU_ADDI;
            uses_imm = 1'b1;
            is_store = 1'b1;
            illegal  = (funct3 != 3'b010);
         end
         BRANCH: begin
            is_branch = 1'b1;
            case (funct3)
               3'b000:  alu_sel = ALU_BEQ;
               3'b001:  alu_sel = ALU_BNE;
               3'b100:  alu_sel = ALU_BLT;
               3'b110:  alu_sel = ALU_BLTU;
               default: illegal = 1'b1;
            endcase
         end
         JAL: begin
            alu_sel   = ALU_JAL;
            uses_imm  = 1'b1;
            writes_rd = rd_nonzero;
         end
         JALR: begin
            alu_sel   = ALU_JALR;
            uses_imm  = 1'b1;
            writes_rd = rd_nonzero;
            illegal   = (funct3 != 3'b000);
         end
         AUIPC: begin
            alu_sel   = ALU_AUIPC;
            uses_imm  = 1'b1;
            writes_rd = rd_nonzero;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32 ALU, register file, PC and data memory.
//  state  | meaning
//  FETCH  | ready for an instruction, latch IR on valid
//  DECODE | classify IR, illegal -> TRAP
//  EXEC   | ALU op from IR; branches retire here
//  MEM    | hold mem_req until ack; stores retire on ack
//  WB     | register write (unless rd = x0) and PC update
//  TRAP   | sticky illegal-instruction stop until reset
module rv_multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid_i,
   input  logic [XLEN-1:0]  instr_i,
   output logic             instr_ready_o,
   input  logic             mem_ack_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [SEL_W-1:0] alu_sel_o,
   output logic             alu_src_imm_o,
   output logic             reg_we_o,
   output logic [1:0]       wb_sel_o,
   output logic             pc_we_o,
   output logic             trap_o
);

   state_t           state;
   logic [XLEN-1:0]  ir;
   logic [SEL_W-1:0] dec_alu_sel;
   logic             is_load, is_store, is_branch, uses_imm, writes_rd, illegal;

   rv_ctrl_decode u_decode (
      .ir        (ir),
      .alu_sel   (dec_alu_sel),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_branch (is_branch),
      .uses_imm  (uses_imm),
      .writes_rd (writes_rd),
      .illegal   (illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         ir    <= '0;
      end else begin
         case (state)
            S_FETCH: if (instr_valid_i) begin
               ir    <= instr_i;
               state <= S_DECODE;
            end
            S_DECODE: state <= illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
               if (is_load || is_store) state <= S_MEM;
               else if (is_branch)      state <= S_FETCH;
               else                     state <= S_WB;
            end
            S_MEM:   if (mem_ack_i) state <= is_load ? S_WB : S_FETCH;
            S_WB:    state <= S_FETCH;
            S_TRAP:  state <= S_TRAP;
            default: state <= S_FETCH;
         endcase
      end
   end

   // A store retires in the cycle its ack arrives, so pc_we follows mem_ack_i there.
   always_comb begin
      instr_ready_o = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      alu_sel_o     = ALU_ADD;
      alu_src_imm_o = 1'b0;
      reg_we_o      = 1'b0;
      wb_sel_o      = 2'b00;
      pc_we_o       = 1'b0;
      trap_o        = 1'b0;
      case (state)
         S_FETCH: instr_ready_o = 1'b1;
         S_EXEC: begin
            alu_sel_o     = dec_alu_sel;
            alu_src_imm_o = uses_imm;
            pc_we_o       = is_branch;
         end
         S_MEM: begin
            mem_req_o = 1'b1;
            mem_we_o  = is_store;
            pc_we_o   = is_store && mem_ack_i;
         end
         S_WB: begin
            reg_we_o = writes_rd;
            wb_sel_o = is_load ? 2'b01 : 2'b00;
            pc_we_o  = 1'b1;
         end
         S_TRAP:  trap_o = 1'b1;
         default: ;
      endcase
   end

endmodule
